// File: rtl/uart_cmd_rx_if.sv
// Signal bundle between the UART line and the command receiver.
// Latency: none (wires only).
// Backpressure: none; every output is a one-cycle pulse or a held value.
//
// Contents:
//   rx                     serial line, idle high, 8N1, LSB first
//   rx_data / rx_valid     last good byte and its one-cycle strobe
//   cmd_addr / cmd_data    last accepted command and cmd_valid strobe
//   frame_err / chk_err    one-cycle error strobes
// Modports: slave = receiver (consumes rx), master = line driver / observer.
interface uart_cmd_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       frame_err;
    logic       chk_err;

    modport slave (
        input  rx,
        output rx_data, rx_valid, cmd_addr, cmd_data, cmd_valid, frame_err, chk_err
    );

    modport master (
        output rx,
        input  rx_data, rx_valid, cmd_addr, cmd_data, cmd_valid, frame_err, chk_err
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// UART byte receiver plus 4-byte command parser (0x55, ADDR, DATA, ADDR+DATA).
// Latency: rx_valid one cycle after the mid-stop-bit sample; cmd_valid one cycle after the checksum byte's rx_valid.
// Backpressure: none; the serial line cannot be stalled, results are strobes.
//
// Ports:
//   clk50m  system clock, rising edge
//   reset   synchronous, active-high
//   bus     uart_cmd_rx_if.slave (rx in; rx_data/rx_valid, cmd_addr/cmd_data/cmd_valid,
//           frame_err, chk_err out)
// Parameters: CLK_HZ, BAUD (BIT_CYC = CLK_HZ/BAUD), TIMEOUT_BITS.
// Build option: define CMD_TIMEOUT_EN to abort a partial command after a gap of
// TIMEOUT_BITS bit periods; without it a partial command waits indefinitely.
module uart_cmd_rx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          clk50m,
    input  logic          reset,
    uart_cmd_rx_if.slave  bus
);

    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    localparam logic [7:0] HDR_BYTE = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } byte_state_t;

    typedef enum logic [1:0] {
        P_HDR,
        P_ADDR,
        P_DATA,
        P_CHK
    } parse_state_t;

    // ------------------------------------------------------------------
    // Line synchronizer. prev_q is a delayed copy of the second flop used
    // only for falling-edge detection; every decision uses sync2_q.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic fall_edge;

    always_ff @(posedge clk50m) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_edge = prev_q & ~sync2_q;

    // ------------------------------------------------------------------
    // Byte FSM
    // ------------------------------------------------------------------
    byte_state_t      bstate_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             frame_err_q;

    always_ff @(posedge clk50m) begin
        if (reset) begin
            bstate_q    <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (bstate_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (fall_edge) begin
                        bstate_q <= START;
                    end
                end
                START: begin
                    // Re-check the line at the start-bit midpoint; a high
                    // level here means the falling edge was a glitch.
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            bstate_q <= IDLE;
                        end else begin
                            bstate_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_q <= {sync2_q, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            bstate_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            bstate_q   <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            bstate_q    <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BREAK: begin
                    // Wait out a held-low line before looking for a new start.
                    cnt_q <= '0;
                    if (sync2_q) begin
                        bstate_q <= IDLE;
                    end
                end
                default: begin
                    bstate_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout (optional)
    // ------------------------------------------------------------------
    parse_state_t pstate_q;
    logic         to_hit;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_BITS * BIT_CYC;
    localparam int TO_W   = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign to_hit = (to_cnt_q == TO_W'(TO_CYC - 1));

    // Counts idle cycles since the last byte of a partial command; parked
    // at zero while waiting for a header.
    always_ff @(posedge clk50m) begin
        if (reset || (pstate_q == P_HDR) || rx_valid_q) begin
            to_cnt_q <= '0;
        end else if (!to_hit) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    logic [31:0] unused_timeout_bits;

    assign unused_timeout_bits = TIMEOUT_BITS;
    assign to_hit              = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command parser FSM, advanced only by received bytes.
    // ------------------------------------------------------------------
    logic [7:0] addr_hold_q;
    logic [7:0] data_hold_q;
    logic [7:0] cmd_addr_q;
    logic [7:0] cmd_data_q;
    logic       cmd_valid_q;
    logic       chk_err_q;
    logic [7:0] chk_sum;

    assign chk_sum = addr_hold_q + data_hold_q;

    always_ff @(posedge clk50m) begin
        if (reset) begin
            pstate_q    <= P_HDR;
            addr_hold_q <= '0;
            data_hold_q <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            if (frame_err_q) begin
                pstate_q <= P_HDR;
            end else if (rx_valid_q) begin
                case (pstate_q)
                    P_HDR: begin
                        if (rx_data_q == HDR_BYTE) begin
                            pstate_q <= P_ADDR;
                        end
                    end
                    P_ADDR: begin
                        // 0x55 here is payload; there is no mid-frame resync.
                        addr_hold_q <= rx_data_q;
                        pstate_q    <= P_DATA;
                    end
                    P_DATA: begin
                        data_hold_q <= rx_data_q;
                        pstate_q    <= P_CHK;
                    end
                    P_CHK: begin
                        if (rx_data_q == chk_sum) begin
                            cmd_addr_q  <= addr_hold_q;
                            cmd_data_q  <= data_hold_q;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            chk_err_q <= 1'b1;
                        end
                        pstate_q <= P_HDR;
                    end
                    default: begin
                        pstate_q <= P_HDR;
                    end
                endcase
            end else if (to_hit && (pstate_q != P_HDR)) begin
                pstate_q <= P_HDR;
            end
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.chk_err   = chk_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: byte table plus hand-written command,
// glitch, timeout and reset sequences. BIT_CYC is 10 to keep the run short.
module tb_uart_cmd_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 5_000_000;
    localparam int BC     = CLK_HZ / BAUD;

    logic clk;
    logic reset;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk50m (clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor, sampled on the falling edge.
    int         cyc = 0;
    int         n_rxv = 0, n_cmd = 0, n_ferr = 0, n_cerr = 0, n_consec = 0;
    int         last_rxv_cyc = 0, cmd_lat = -1;
    logic [7:0] last_rx = 8'h00;
    logic       p_rxv = 1'b0, p_cmd = 1'b0, p_ferr = 1'b0, p_cerr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_rxv        = n_rxv + 1;
            last_rx      = bus.rx_data;
            last_rxv_cyc = cyc;
        end
        if (bus.cmd_valid) begin
            n_cmd   = n_cmd + 1;
            cmd_lat = cyc - last_rxv_cyc;
        end
        if (bus.frame_err) n_ferr = n_ferr + 1;
        if (bus.chk_err)   n_cerr = n_cerr + 1;
        if ((bus.rx_valid && p_rxv) || (bus.cmd_valid && p_cmd) ||
            (bus.frame_err && p_ferr) || (bus.chk_err && p_cerr))
            n_consec = n_consec + 1;
        p_rxv  = bus.rx_valid;
        p_cmd  = bus.cmd_valid;
        p_ferr = bus.frame_err;
        p_cerr = bus.chk_err;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // One 8N1 frame; a low stop bit is followed by two more low bit times.
    task automatic send_byte(input logic [7:0] d, input logic stop_hi);
        bus.rx = 1'b0;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (BC) @(negedge clk);
        end
        bus.rx = stop_hi;
        repeat (BC) @(negedge clk);
        if (!stop_hi) repeat (2 * BC) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * BC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, 1'b1);
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       stop_hi;
        int         exp_rxv;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    int s_rxv, s_cmd, s_ferr, s_cerr;

    task automatic snap();
        s_rxv  = n_rxv;
        s_cmd  = n_cmd;
        s_ferr = n_ferr;
        s_cerr = n_cerr;
    endtask

    initial begin
        logic [7:0] v;

        vecs[0] = '{dat: 8'hA5, stop_hi: 1'b1, exp_rxv: 1, exp_ferr: 0, exp_data: 8'hA5};
        vecs[1] = '{dat: 8'h00, stop_hi: 1'b1, exp_rxv: 1, exp_ferr: 0, exp_data: 8'h00};
        vecs[2] = '{dat: 8'hFF, stop_hi: 1'b1, exp_rxv: 1, exp_ferr: 0, exp_data: 8'hFF};
        vecs[3] = '{dat: 8'h55, stop_hi: 1'b0, exp_rxv: 0, exp_ferr: 1, exp_data: 8'hFF};
        vecs[4] = '{dat: 8'h3C, stop_hi: 1'b1, exp_rxv: 1, exp_ferr: 0, exp_data: 8'h3C};

        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset rx_data",  {24'd0, bus.rx_data},  32'h00);
        check("reset cmd_addr", {24'd0, bus.cmd_addr}, 32'h00);
        check("reset cmd_data", {24'd0, bus.cmd_data}, 32'h00);
        check("reset pulses",   {28'd0, bus.rx_valid, bus.cmd_valid, bus.frame_err, bus.chk_err}, 32'h0);

        // Byte table
        for (int i = 0; i < 5; i++) begin
            snap();
            send_byte(vecs[i].dat, vecs[i].stop_hi);
            check($sformatf("vec%0d rx_valid count", i), n_rxv - s_rxv, vecs[i].exp_rxv);
            check($sformatf("vec%0d frame_err count", i), n_ferr - s_ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d rx_data", i), {24'd0, bus.rx_data}, {24'd0, vecs[i].exp_data});
        end

        // Good command frame
        snap();
        send_frame(8'h55, 8'h03, 8'h7F, 8'h82);
        check("cmd1 rx_valid count", n_rxv - s_rxv, 4);
        check("cmd1 cmd_valid count", n_cmd - s_cmd, 1);
        check("cmd1 chk_err count", n_cerr - s_cerr, 0);
        check("cmd1 cmd_addr", {24'd0, bus.cmd_addr}, 32'h03);
        check("cmd1 cmd_data", {24'd0, bus.cmd_data}, 32'h7F);
        check("cmd1 latency", cmd_lat, 1);

        // Bad checksum: outputs hold, next frame accepted
        snap();
        send_frame(8'h55, 8'h11, 8'h22, 8'h00);
        check("bad chk_err count", n_cerr - s_cerr, 1);
        check("bad cmd_valid count", n_cmd - s_cmd, 0);
        check("bad cmd_addr hold", {24'd0, bus.cmd_addr}, 32'h03);
        check("bad cmd_data hold", {24'd0, bus.cmd_data}, 32'h7F);
        snap();
        send_frame(8'h55, 8'h11, 8'h22, 8'h33);
        check("after bad cmd_valid count", n_cmd - s_cmd, 1);
        check("after bad cmd_addr", {24'd0, bus.cmd_addr}, 32'h11);
        check("after bad cmd_data", {24'd0, bus.cmd_data}, 32'h22);

        // 0x55 as payload
        snap();
        send_frame(8'h55, 8'h55, 8'h01, 8'h56);
        check("payload55 cmd_valid count", n_cmd - s_cmd, 1);
        check("payload55 cmd_addr", {24'd0, bus.cmd_addr}, 32'h55);
        check("payload55 cmd_data", {24'd0, bus.cmd_data}, 32'h01);

        // Glitch shorter than half a bit, then a real byte
        snap();
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * BC) @(negedge clk);
        check("glitch rx_valid count", n_rxv - s_rxv, 0);
        check("glitch frame_err count", n_ferr - s_ferr, 0);
        snap();
        send_byte(8'hA5, 1'b1);
        check("post-glitch rx_valid count", n_rxv - s_rxv, 1);
        check("post-glitch rx_data", {24'd0, bus.rx_data}, 32'hA5);

        // Long gap inside a partial command
        snap();
        send_byte(8'h55, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (23 * BC) @(negedge clk);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
`ifdef CMD_TIMEOUT_EN
        check("gap cmd_valid count", n_cmd - s_cmd, 0);
        check("gap cmd_addr hold", {24'd0, bus.cmd_addr}, 32'h55);
`else
        check("gap cmd_valid count", n_cmd - s_cmd, 1);
        check("gap cmd_addr", {24'd0, bus.cmd_addr}, 32'h10);
        check("gap cmd_data", {24'd0, bus.cmd_data}, 32'h20);
`endif

        // Reset during bit 4 of 0x55
        v = 8'h55;
        bus.rx = 1'b0;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = v[i];
            repeat (BC) @(negedge clk);
        end
        bus.rx = v[4];
        repeat (BC / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        reset  = 1'b0;
        snap();
        repeat (3 * BC) @(negedge clk);
        check("midreset rx_data", {24'd0, bus.rx_data}, 32'h00);
        check("midreset cmd_addr", {24'd0, bus.cmd_addr}, 32'h00);
        check("midreset cmd_data", {24'd0, bus.cmd_data}, 32'h00);
        check("midreset pulses", (n_rxv - s_rxv) + (n_cmd - s_cmd) + (n_ferr - s_ferr) + (n_cerr - s_cerr), 0);
        snap();
        send_frame(8'h55, 8'h01, 8'h02, 8'h03);
        check("postreset cmd_valid count", n_cmd - s_cmd, 1);
        check("postreset cmd_addr", {24'd0, bus.cmd_addr}, 32'h01);
        check("postreset cmd_data", {24'd0, bus.cmd_data}, 32'h02);

        check("back-to-back pulses", n_consec, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
